// File: rtl/huff_pkg.sv
// ---------------------------------------------------------------------------
// huff_pkg
// Shared definitions for the Huffman sort controller slice.
//   - NODE_W          : width of one node (weight in the upper nibble,
//                       symbol/id in the lower nibble)
//   - KEY_HI / KEY_LO : bounds of the weight field that decides ordering
//   - state_e         : controller phases (load a frame, sort it, drain it)
//   - node_key()      : extracts the weight field from a node
// ---------------------------------------------------------------------------
package huff_pkg;

  localparam int NODE_W = 8;
  localparam int KEY_HI = 7;
  localparam int KEY_LO = 4;
  localparam int KEY_W  = KEY_HI - KEY_LO + 1;

  typedef enum logic [1:0] {
    ST_LOAD  = 2'd0,
    ST_SORT  = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  function automatic logic [KEY_W-1:0] node_key(input logic [NODE_W-1:0] node);
    return node[KEY_HI:KEY_LO];
  endfunction

endpackage

// File: rtl/huff_sort_ctrl_if.sv
// ---------------------------------------------------------------------------
// huff_sort_ctrl_if
// Input and output streaming handshakes of the sort controller.
//   in_valid  : producer has a node on in_data
//   in_ready  : controller accepts a node this cycle
//   in_data   : node entering the frame buffer
//   out_valid : controller presents a sorted node on out_data
//   out_ready : consumer accepts the node this cycle
//   out_data  : sorted node
//   out_last  : out_data is the final node of the frame
// Modports:
//   master : the environment side (drives in_*, out_ready)
//   slave  : the controller side (drives in_ready, out_*)
// ---------------------------------------------------------------------------
interface huff_sort_ctrl_if
  import huff_pkg::*;
#(
  parameter int W = NODE_W
);

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;
  logic         out_last;

  modport master (
    output in_valid,
    output in_data,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_data,
    input  out_last
  );

  modport slave (
    input  in_valid,
    input  in_data,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_data,
    output out_last
  );

endinterface

// File: rtl/huff_sort_ctrl_cmp_swap.sv
// ---------------------------------------------------------------------------
// cmp_swap
// Combinational compare-swap on the weight field of two nodes.
//   a, b   : nodes at the lower and upper position of the pair
//   lo, hi : nodes to write back to the lower and upper position
// The pair is exchanged only when a's weight is strictly greater than b's,
// so nodes of equal weight keep their relative order (stable sort). The
// symbol bits travel with their node untouched.
// ---------------------------------------------------------------------------
module cmp_swap
  import huff_pkg::*;
(
  input  logic [NODE_W-1:0] a,
  input  logic [NODE_W-1:0] b,
  output logic [NODE_W-1:0] lo,
  output logic [NODE_W-1:0] hi
);

  logic swap;

  assign swap = node_key(a) > node_key(b);
  assign lo   = swap ? b : a;
  assign hi   = swap ? a : b;

endmodule

// File: rtl/huff_sort_ctrl.sv
// ---------------------------------------------------------------------------
// huff_sort_ctrl
// Collects a frame of N nodes, sorts it ascending by weight with one shared
// compare-swap unit (odd-even transposition, one pair per cycle), then
// streams the sorted frame out.
//   CLK  : clock, all logic on the rising edge
//   RST  : synchronous active-high reset; discards any partial frame
//   bus  : huff_sort_ctrl_if.slave (input and output handshakes)
//   busy : high while sorting or draining
// Parameter N: nodes per frame, even, 2..16.
//
// Phase timing for a frame whose last node is accepted at edge k:
//   SORT runs over edges k+1 .. k+N(N-1)/2 and the final sort edge moves to
//   DRAIN, so out_valid is first seen after edge k+N(N-1)/2. The out_last
//   handshake returns to LOAD on the same edge, so loading and draining
//   never overlap.
// ---------------------------------------------------------------------------
module huff_sort_ctrl
  import huff_pkg::*;
#(
  parameter int N = 8
) (
  input  logic             CLK,
  input  logic             RST,
  huff_sort_ctrl_if.slave  bus,
  output logic             busy
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam int PW = IW + 1;

  // With N=2 the odd passes contain no pairs, so a single even pass is the
  // whole sort; otherwise N passes alternate even/odd.
  localparam int LAST_P = (N == 2) ? 0 : N - 1;

  localparam logic [IW-1:0] LAST_IDX    = IW'(N - 1);
  localparam logic [IW-1:0] LAST_J_EVEN = IW'(N / 2 - 1);
  localparam logic [IW-1:0] LAST_J_ODD  = IW'((N > 2) ? (N / 2 - 2) : 0);

  state_e state_q, state_d;

  logic [NODE_W-1:0] node_buf [N];
  logic [IW-1:0]     wi_q;
  logic [IW-1:0]     ri_q;
  logic [IW-1:0]     j_q;
  logic [PW-1:0]     p_q;

  logic [IW-1:0]     idx_lo;
  logic [IW-1:0]     idx_hi;
  logic [NODE_W-1:0] cs_lo;
  logic [NODE_W-1:0] cs_hi;
  logic              pair_last;
  logic              pass_last;
  logic              load_last;
  logic              drain_last;

  // Pair position: even passes start at 0, odd passes at 1, stepping by two.
  assign idx_lo = IW'((int'(j_q) << 1) + int'(p_q[0]));
  assign idx_hi = idx_lo + IW'(1);

  assign pair_last  = p_q[0] ? (j_q == LAST_J_ODD) : (j_q == LAST_J_EVEN);
  assign pass_last  = (p_q == PW'(LAST_P));
  assign load_last  = (wi_q == LAST_IDX);
  assign drain_last = (ri_q == LAST_IDX);

  // One comparator serves every pair; the buffer mux selects which pair.
  cmp_swap u_cmp_swap (
    .a  (node_buf[idx_lo]),
    .b  (node_buf[idx_hi]),
    .lo (cs_lo),
    .hi (cs_hi)
  );

  // -------------------------------------------------------------------------
  // Next-state and output decode
  // -------------------------------------------------------------------------
  always_comb begin
    // NOTE: every output of this block gets a default before the case, so no
    // path can leave one unassigned and infer a latch.
    state_d       = state_q;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    bus.out_data  = '0;
    bus.out_last  = 1'b0;
    busy          = 1'b0;

    unique case (state_q)
      ST_LOAD: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid && load_last) begin
          state_d = ST_SORT;
        end
      end

      ST_SORT: begin
        busy = 1'b1;
        if (pair_last && pass_last) begin
          state_d = ST_DRAIN;
        end
      end

      ST_DRAIN: begin
        busy          = 1'b1;
        bus.out_valid = 1'b1;
        bus.out_data  = node_buf[ri_q];
        bus.out_last  = drain_last;
        if (bus.out_ready && drain_last) begin
          state_d = ST_LOAD;
        end
      end

      default: begin
        state_d = ST_LOAD;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // State register, indices and frame buffer
  // -------------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= ST_LOAD;
      wi_q    <= '0;
      ri_q    <= '0;
      j_q     <= '0;
      p_q     <= '0;
      // NOTE: the buffer is a register array, not a RAM, and is cleared on
      // reset so that nothing from an aborted frame can reach the output.
      for (int k = 0; k < N; k++) begin
        node_buf[k] <= '0;
      end
    end else begin
      // NOTE: non-blocking assignments throughout, so the compare-swap reads
      // the pair as it stood before this edge and writes both halves back
      // together.
      state_q <= state_d;

      unique case (state_q)
        ST_LOAD: begin
          if (bus.in_valid) begin
            node_buf[wi_q] <= bus.in_data;
            if (load_last) begin
              wi_q <= '0;
              p_q  <= '0;
              j_q  <= '0;
            end else begin
              wi_q <= wi_q + IW'(1);
            end
          end
        end

        ST_SORT: begin
          node_buf[idx_lo] <= cs_lo;
          node_buf[idx_hi] <= cs_hi;
          if (pair_last) begin
            j_q <= '0;
            if (pass_last) begin
              p_q  <= '0;
              ri_q <= '0;
            end else begin
              p_q <= p_q + PW'(1);
            end
          end else begin
            j_q <= j_q + IW'(1);
          end
        end

        ST_DRAIN: begin
          // ri only moves on a handshake, which keeps out_data steady while
          // the consumer stalls.
          if (bus.out_ready) begin
            ri_q <= drain_last ? '0 : ri_q + IW'(1);
          end
        end

        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_huff_sort_ctrl.sv
// ---------------------------------------------------------------------------
// tb_huff_sort_ctrl
// Directed bench for huff_sort_ctrl with N=8. Inputs change and outputs are
// sampled on the falling edge; the DUT acts on the rising edge.
// ---------------------------------------------------------------------------
module tb_huff_sort_ctrl;

  logic CLK = 1'b0;
  logic RST;
  logic busy;

  int checks   = 0;
  int errors   = 0;
  int edge_cnt = 0;
  int last_acc = 0;

  logic [7:0] frame_v [8];
  logic [7:0] exp_v   [8];

  huff_sort_ctrl_if #(.W(8)) bus ();

  huff_sort_ctrl #(.N(8)) dut (
    .CLK  (CLK),
    .RST  (RST),
    .bus  (bus.slave),
    .busy (busy)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) edge_cnt <= edge_cnt + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Starts and ends on a falling edge. Ends on the falling edge right after
  // the edge that accepted node 7; last_acc holds that edge's number.
  task automatic load_frame(input string tag, input bit hold_ff);
    for (int i = 0; i < 8; i++) begin
      int waits = 0;
      bus.in_valid = 1'b1;
      bus.in_data  = frame_v[i];
      while (!bus.in_ready && waits < 100) begin
        @(negedge CLK);
        waits++;
      end
      if (i == 0) check({tag, "_load_wait0"}, waits, 0);
      if (waits >= 100) check({tag, "_load_timeout"}, 0, 1);
      @(negedge CLK);
      last_acc = edge_cnt;
    end
    if (hold_ff) begin
      bus.in_valid = 1'b1;
      bus.in_data  = 8'hFF;
    end else begin
      bus.in_valid = 1'b0;
      bus.in_data  = 8'h00;
    end
  endtask

  // Runs from the falling edge after the last accept until the falling edge
  // after the out_last handshake. bp selects the 1,0,0 out_ready pattern.
  task automatic drain_frame(input string tag, input bit bp);
    int         got       = 0;
    int         cyc       = 0;
    int         vcyc      = 0;
    int         busy_cyc  = 0;
    bit         seen      = 1'b0;
    bit         stalled   = 1'b0;
    logic [7:0] held      = 8'h00;
    while (got < 8 && cyc < 400) begin
      bus.out_ready = bp ? (vcyc % 3 == 0) : 1'b1;
      if (busy) begin
        busy_cyc++;
        check({tag, "_in_ready_busy"}, bus.in_ready, 1'b0);
      end
      if (bus.out_valid) begin
        if (!seen) begin
          seen = 1'b1;
          check({tag, "_latency"}, edge_cnt - last_acc, 28);
        end
        if (stalled) check($sformatf("%s_stable%0d", tag, got), bus.out_data, held);
        check($sformatf("%s_last%0d", tag, got), bus.out_last, (got == 7));
        if (bus.out_ready) begin
          check($sformatf("%s_data%0d", tag, got), bus.out_data, exp_v[got]);
          got++;
          stalled = 1'b0;
        end else begin
          stalled = 1'b1;
          held    = bus.out_data;
        end
        vcyc++;
      end
      @(negedge CLK);
      cyc++;
    end
    if (got < 8) check({tag, "_drain_timeout"}, got, 8);
    check({tag, "_ret_in_ready"}, bus.in_ready, 1'b1);
    check({tag, "_ret_out_valid"}, bus.out_valid, 1'b0);
    check({tag, "_ret_busy"}, busy, 1'b0);
    if (!bp) check({tag, "_busy_cycles"}, busy_cyc, 36);
    bus.out_ready = 1'b1;
  endtask

  initial begin
    RST           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_data   = 8'h00;
    bus.out_ready = 1'b0;

    // Reset state
    repeat (2) @(negedge CLK);
    check("rst_in_ready", bus.in_ready, 1'b1);
    check("rst_out_valid", bus.out_valid, 1'b0);
    check("rst_out_data", bus.out_data, 8'h00);
    check("rst_out_last", bus.out_last, 1'b0);
    check("rst_busy", busy, 1'b0);
    RST = 1'b0;

    // Reverse order
    frame_v = '{8'h70, 8'h61, 8'h52, 8'h43, 8'h34, 8'h25, 8'h16, 8'h07};
    exp_v   = '{8'h07, 8'h16, 8'h25, 8'h34, 8'h43, 8'h52, 8'h61, 8'h70};
    load_frame("rev", 1'b0);
    drain_frame("rev", 1'b0);

    // Stability on equal weights
    frame_v = '{8'h31, 8'h12, 8'h33, 8'h14, 8'h05, 8'h36, 8'h17, 8'h08};
    exp_v   = '{8'h05, 8'h08, 8'h12, 8'h14, 8'h17, 8'h31, 8'h33, 8'h36};
    load_frame("tie", 1'b0);
    drain_frame("tie", 1'b0);

    // Already sorted
    frame_v = '{8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77};
    exp_v   = '{8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77};
    load_frame("srt", 1'b0);
    drain_frame("srt", 1'b0);

    // Backpressure
    frame_v = '{8'h52, 8'h13, 8'h74, 8'h05, 8'h66, 8'h21, 8'h37, 8'h40};
    exp_v   = '{8'h05, 8'h13, 8'h21, 8'h37, 8'h40, 8'h52, 8'h66, 8'h74};
    load_frame("bp", 1'b0);
    drain_frame("bp", 1'b1);

    // Reset mid-SORT, then a fresh frame
    frame_v = '{8'h7A, 8'h6B, 8'h5C, 8'h4D, 8'h3E, 8'h2F, 8'h19, 8'h08};
    load_frame("mid", 1'b0);
    repeat (10) @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    check("mid_rst_in_ready", bus.in_ready, 1'b1);
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_out_valid", bus.out_valid, 1'b0);
    check("mid_rst_out_data", bus.out_data, 8'h00);
    frame_v = '{8'h20, 8'h10, 8'h40, 8'h30, 8'h60, 8'h50, 8'h00, 8'h70};
    exp_v   = '{8'h00, 8'h10, 8'h20, 8'h30, 8'h40, 8'h50, 8'h60, 8'h70};
    load_frame("fresh", 1'b0);
    drain_frame("fresh", 1'b0);

    // Input held during SORT/DRAIN: 0xFF becomes node 0 of the next frame
    frame_v = '{8'h43, 8'h21, 8'h65, 8'h07, 8'h32, 8'h54, 8'h76, 8'h10};
    exp_v   = '{8'h07, 8'h10, 8'h21, 8'h32, 8'h43, 8'h54, 8'h65, 8'h76};
    load_frame("hold", 1'b1);
    drain_frame("hold", 1'b0);
    check("hold_ff_presented", bus.in_data, 8'hFF);
    frame_v = '{8'hFF, 8'h3A, 8'h1B, 8'h3C, 8'h0D, 8'h2E, 8'h1F, 8'h09};
    exp_v   = '{8'h0D, 8'h09, 8'h1B, 8'h1F, 8'h2E, 8'h3A, 8'h3C, 8'hFF};
    load_frame("ff", 1'b0);
    drain_frame("ff", 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/huff_sort_ctrl.md
# huff_sort_ctrl

Sequencing controller for the Huffman front end: collects a frame of N 8-bit nodes (weight in [7:4], symbol/id in [3:0]), sorts them ascending by weight with a single shared compare-swap unit using odd-even transposition, then streams the sorted frame out. It sits between the frequency counter and the tree builder, replacing a fixed network of per-pair sorters with one time-multiplexed comparator.

## Interface
- N, 8, nodes per frame; even, 2..16
- W, 8, node width
- KEY_HI, 7, MSB of the weight field
- KEY_LO, 4, LSB of the weight field
- CLK  in  1  single clock, all logic on rising edge
- RST  in  1  synchronous, active-high reset
- in_valid  in  1  input node present
- in_ready  out  1  block accepts input; high only in LOAD
- in_data  in  W  input node
- out_valid  out  1  sorted node present
- out_ready  in  1  downstream accepts output
- out_data  out  W  sorted node
- out_last  out  1  marks the final node of the frame (index N-1)
- busy  out  1  high in SORT and DRAIN

## Operation
- Storage: N-entry register buffer buf[0..N-1]; write index wi, read index ri, pass counter p, pair index j.
- States: LOAD, SORT, DRAIN.
- LOAD:
  - in_ready=1.
  - On in_valid&&in_ready: buf[wi]<=in_data, wi++.
  - After accepting entry N-1: wi<=0, p<=0, j<=0, go to SORT.
- SORT:
  - One compare-swap per cycle.
  - Even pass (p even): pairs (0,1),(2,3)…(N-2,N-1), giving N/2 cycles.
  - Odd pass (p odd): pairs (1,2),(3,4)…(N-3,N-2), giving N/2-1 cycles.
  - Each cycle reads buf[i], buf[i+1] and writes back the compare-swap result in the same cycle.
  - Swap only when buf[i][KEY_HI:KEY_LO] > buf[i+1][KEY_HI:KEY_LO] (strict). Equal weights never swap, so the sort is stable.
  - After the last pair of pass N-1: ri<=0, go to DRAIN.
  - Total SORT cycles: SC = N(N-1)/2, which is 28 for N=8.
- DRAIN:
  - out_valid=1, out_data=buf[ri], out_last=(ri==N-1).
  - On out_valid&&out_ready: ri++.
  - On the handshake with out_last=1: go to LOAD.
- Inputs are ignored outside LOAD: in_ready=0 and in_data is never sampled.
- out_data is held stable while out_valid&&!out_ready.
- Only the weight field decides ordering; the [3:0] bits travel with their node unchanged.

## Timing
- Reset values (RST high at a clock edge): state=LOAD, buf all 0x00, wi=ri=p=j=0.
  - Outputs after that edge: in_ready=1, out_valid=0, out_data=0x00, out_last=0, busy=0.
- Reset has priority over every other event, including mid-SORT and mid-DRAIN; the partial frame is discarded.
- Latency:
  - Last input accepted at edge k.
  - SORT occupies edges k+1..k+SC.
  - out_valid is first high after edge k+SC (the edge that leaves SORT); for N=8 that is 28 edges after the last accept.
- Throughput:
  - With out_ready held high, DRAIN lasts exactly N cycles.
  - in_ready returns high the cycle after the out_last handshake.
  - Frame period is at least N+SC+N cycles.
- The handshake on out_last and the re-entry into LOAD happen on the same edge. There is no simultaneous load/drain overlap.
- in_valid held high during SORT/DRAIN is not consumed; that same word is accepted on the first LOAD cycle.

## Structure
- Shared package huff_pkg:
  - state typedef (LOAD, SORT, DRAIN)
  - node width constant
  - weight field bounds (KEY_HI, KEY_LO)
- Sub-module cmp_swap: combinational, two W-bit nodes in, lo/hi out, strict-greater swap on the weight field. It is instantiated once and shared by all pairs.
- Indices sized to $clog2(N); pass counter sized to $clog2(N)+1.

## Test plan
- Reverse order:
  - Stimulus: load 0x70,0x61,0x52,0x43,0x34,0x25,0x16,0x07 with out_ready=1.
  - Required: outputs 0x07,0x16,0x25,0x34,0x43,0x52,0x61,0x70; out_last only on 0x70; first out_valid exactly 28 edges after the last accept.
- Stability on ties:
  - Stimulus: load 0x31,0x12,0x33,0x14,0x05,0x36,0x17,0x08.
  - Required: outputs 0x05,0x08,0x12,0x14,0x17,0x31,0x33,0x36.
- Already sorted:
  - Stimulus: load 0x00,0x11,…,0x77.
  - Required: identical order out; busy high for 28+8 cycles.
- Backpressure:
  - Stimulus: toggle out_ready 1,0,0,1,… in DRAIN.
  - Required: out_data stable while stalled; no node dropped or duplicated; return to LOAD only after the out_last handshake.
- Reset mid-SORT:
  - Stimulus: assert RST at SORT cycle 10.
  - Required: next cycle in_ready=1, busy=0, out_valid=0. A fresh frame 0x20,0x10,… then sorts correctly with no stale data.
- Input during busy:
  - Stimulus: hold in_valid=1, in_data=0xFF through SORT/DRAIN.
  - Required: in_ready stays 0; 0xFF is accepted as node 0 of the next frame, on the first LOAD cycle after the out_last handshake.
